// File: rtl/id_ex_reg_pkg.sv
// Shared control encoding for the ID/EX pipeline register.
//   aluop_e     : 3-bit ALUOp codes {ALUOp1,ALUOp2,ALUOp3} decoded by ALU control
//   ctrl_t      : the six EX/MEM/WB control bits plus the ALUOp field
//   CtrlBubble  : control word of an inserted bubble (no side effects)
//   sat_inc     : saturating increment for the bubble counter
package id_ex_reg_pkg;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSlt   = 3'b001,
        AluSub   = 3'b010,
        AluAddI  = 3'b011,
        AluRtype = 3'b100,
        AluLui   = 3'b101,
        AluOr    = 3'b110
    } aluop_e;

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [2:0] aluop;
    } ctrl_t;

    // A bubble must never write a register or touch memory.
    localparam ctrl_t CtrlBubble = '{
        alusrc:   1'b0,
        regdst:   1'b0,
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        memtoreg: 1'b0,
        aluop:    AluAdd
    };

    localparam int unsigned BubbleCntW = 16;
    localparam logic [BubbleCntW-1:0] BubbleCntMax = '1;

    function automatic logic [BubbleCntW-1:0] sat_inc(input logic [BubbleCntW-1:0] v);
        return (v == BubbleCntMax) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   ex_valid, ex_memread, ex_rt : instruction currently in EX
//   id_valid, id_rs, id_rt      : instruction currently in ID
//   hz_stall                    : EX load writes a register the ID instruction reads
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hz_stall
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hz_stall = ex_valid & ex_memread & id_valid & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
//   clk, rst_n     : rising-edge clock, synchronous active-low reset
//   stall, flush   : hold stage / replace stage with a bubble
//   id_*           : decoded instruction from ID
//   ex_*           : registered copy for EX (ex_ALUOp1..3 = ex_aluop[2..0])
//   hz_stall       : load-use hazard; PC and IF/ID must hold
//   bubble_cnt     : saturating count of load-use bubbles inserted
// Priority per cycle: reset > flush > stall > hazard bubble > load.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [5:0]    id_funct,
    input  logic [2:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_shamt,
    output logic [5:0]    ex_funct,
    output logic [2:0]    ex_aluop,
    output logic          ex_alusrc,
    output logic          ex_regdst,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          ex_ALUOp1,
    output logic          ex_ALUOp2,
    output logic          ex_ALUOp3,
    output logic          hz_stall,
    output logic [15:0]   bubble_cnt
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    shamt;
        logic [5:0]    funct;
        ctrl_t         ctrl;
    } stage_t;

    stage_t      stage_q, stage_d;
    stage_t      id_stage, bubble_stage;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        hz;

    hazard_detect u_hazard_detect (
        .ex_valid   (stage_q.valid),
        .ex_memread (stage_q.ctrl.memread),
        .ex_rt      (stage_q.rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .hz_stall   (hz)
    );

    always_comb begin
        bubble_stage      = '0;
        bubble_stage.ctrl = CtrlBubble;

        id_stage.valid         = id_valid;
        id_stage.pc            = id_pc;
        id_stage.rd1           = id_rd1;
        id_stage.rd2           = id_rd2;
        id_stage.imm           = id_imm;
        id_stage.rs            = id_rs;
        id_stage.rt            = id_rt;
        id_stage.rd            = id_rd;
        id_stage.shamt         = id_shamt;
        id_stage.funct         = id_funct;
        id_stage.ctrl.alusrc   = id_alusrc;
        id_stage.ctrl.regdst   = id_regdst;
        id_stage.ctrl.regwrite = id_regwrite;
        id_stage.ctrl.memread  = id_memread;
        id_stage.ctrl.memwrite = id_memwrite;
        id_stage.ctrl.memtoreg = id_memtoreg;
        id_stage.ctrl.aluop    = id_aluop;
    end

    // Next-state selection; reset is applied in the register block.
    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            // Taken branch/jump: squash regardless of stall or hazard, not counted.
            stage_d = bubble_stage;
        end else if (stall) begin
            // Downstream busy: hold contents and counter.
            stage_d = stage_q;
        end else if (hz) begin
            // Load-use: the ID instruction stays in IF/ID and retries next cycle.
            stage_d      = bubble_stage;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            stage_d = id_stage;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q      <= bubble_stage;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = stage_q.valid;
    assign ex_pc       = stage_q.pc;
    assign ex_rd1      = stage_q.rd1;
    assign ex_rd2      = stage_q.rd2;
    assign ex_imm      = stage_q.imm;
    assign ex_rs       = stage_q.rs;
    assign ex_rt       = stage_q.rt;
    assign ex_rd       = stage_q.rd;
    assign ex_shamt    = stage_q.shamt;
    assign ex_funct    = stage_q.funct;
    assign ex_aluop    = stage_q.ctrl.aluop;
    assign ex_alusrc   = stage_q.ctrl.alusrc;
    assign ex_regdst   = stage_q.ctrl.regdst;
    assign ex_regwrite = stage_q.ctrl.regwrite;
    assign ex_memread  = stage_q.ctrl.memread;
    assign ex_memwrite = stage_q.ctrl.memwrite;
    assign ex_memtoreg = stage_q.ctrl.memtoreg;
    assign ex_ALUOp1   = stage_q.ctrl.aluop[2];
    assign ex_ALUOp2   = stage_q.ctrl.aluop[1];
    assign ex_ALUOp3   = stage_q.ctrl.aluop[0];
    assign hz_stall    = hz;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
